// File: rtl/filt_pkg.sv
// Shared definitions for the noise-filter datapath.
// PIX_W        : default pixel width.
// absdiff_lat  : register ranks from input sample to valid output of pix_absdiff_pipe,
//                used by upstream alignment logic and the testbench.
package filt_pkg;

    localparam int unsigned PIX_W = 8;

    function automatic int unsigned absdiff_lat(input int unsigned stages);
        return stages + 1;
    endfunction

endpackage

// File: rtl/pix_absdiff_pipe_if.sv
// Handshake bundle for pix_absdiff_pipe.
// Input side : in_valid, in_ready, a, b, thresh.
// Output side: out_valid, out_ready, diff (DATA_W+1, two's complement a-b),
//              absdiff (|a-b|), edge_flag (absdiff > thresh).
// slave modport is the pipeline's view; master is the upstream/downstream view.
interface pix_absdiff_pipe_if
    import filt_pkg::*;
#(
    parameter int unsigned DATA_W = PIX_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] thresh;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] absdiff;
    logic              edge_flag;

    modport slave (
        input  in_valid, a, b, thresh, out_ready,
        output in_ready, out_valid, diff, absdiff, edge_flag
    );

    modport master (
        output in_valid, a, b, thresh, out_ready,
        input  in_ready, out_valid, diff, absdiff, edge_flag
    );

endinterface

// File: rtl/sub_seg.sv
// One segment of the borrow chain: s = x + ~y + cin over SEG_W bits.
// x, y : operand slices; cin : carry in (1 = no borrow into this slice)
// s    : result slice;   cout: carry out (1 = no borrow out of this slice)
module sub_seg #(
    parameter int unsigned SEG_W = 4
) (
    input  logic [SEG_W-1:0] x,
    input  logic [SEG_W-1:0] y,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout
);
    // Controlled add/subtract cell; mode is permanently subtract.
    logic             sub_mode;
    logic [SEG_W-1:0] y_eff;
    logic [SEG_W:0]   sum;

    assign sub_mode = 1'b1;
    assign y_eff    = y ^ {SEG_W{sub_mode}};
    assign sum      = {1'b0, x} + {1'b0, y_eff} + {{SEG_W{1'b0}}, cin};
    assign s        = sum[SEG_W-1:0];
    assign cout     = sum[SEG_W];

endmodule

// File: rtl/pix_absdiff_pipe.sv
// Pipelined pixel subtractor: diff = a - b, absdiff = |a - b|, edge_flag = absdiff > thresh.
// clk, rst_n : single clock, synchronous active-low reset.
// bus        : slave side of pix_absdiff_pipe_if (valid/ready in, valid/ready out).
// STAGES borrow-chain segments each register one slice plus carry; a final rank registers
// the outputs. Flow control is a global stall: everything holds while the output is
// valid and not accepted.
module pix_absdiff_pipe
    import filt_pkg::*;
#(
    parameter int unsigned DATA_W = PIX_W,
    parameter int unsigned STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    pix_absdiff_pipe_if.slave bus
);
    localparam int unsigned SEG_W = DATA_W / STAGES;

    logic stall;
    logic advance;

    // Segment pipeline registers. Operands and thresh travel with the partial result so
    // each segment sees its operand slice in the same cycle as its carry-in.
    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [DATA_W-1:0] a_q [STAGES];
    logic [DATA_W-1:0] a_d [STAGES];
    logic [DATA_W-1:0] b_q [STAGES];
    logic [DATA_W-1:0] b_d [STAGES];
    logic [DATA_W-1:0] t_q [STAGES];
    logic [DATA_W-1:0] t_d [STAGES];
    logic [DATA_W-1:0] s_q [STAGES];
    logic [DATA_W-1:0] s_d [STAGES];

    // Final rank.
    logic              out_valid_q, out_valid_d;
    logic [DATA_W:0]   diff_q, diff_d;
    logic [DATA_W-1:0] absdiff_q, absdiff_d;
    logic              edge_q, edge_d;

    // What each segment consumes this cycle.
    logic [DATA_W-1:0] src_a [STAGES];
    logic [DATA_W-1:0] src_b [STAGES];
    logic [DATA_W-1:0] src_t [STAGES];
    logic [DATA_W-1:0] src_s [STAGES];
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] src_v;

    logic [STAGES-1:0][SEG_W-1:0] seg_x, seg_y, seg_s;
    logic [STAGES-1:0]            seg_ci, seg_co;

    logic [DATA_W-1:0] full_s;
    logic              neg;
    logic [DATA_W-1:0] mag;

    assign stall   = out_valid_q & ~bus.out_ready;
    assign advance = ~stall;

    always_comb begin
        src_a[0] = bus.a;
        src_b[0] = bus.b;
        src_t[0] = bus.thresh;
        src_s[0] = '0;
        src_c    = '0;
        src_v    = '0;
        src_c[0] = 1'b1;
        src_v[0] = bus.in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_t[k] = t_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
            src_v[k] = v_q[k-1];
        end
    end

    always_comb begin
        seg_x  = '0;
        seg_y  = '0;
        seg_ci = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            seg_x[k]  = src_a[k][k*SEG_W +: SEG_W];
            seg_y[k]  = src_b[k][k*SEG_W +: SEG_W];
            seg_ci[k] = src_c[k];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_seg
        sub_seg #(
            .SEG_W (SEG_W)
        ) u_sub_seg (
            .x    (seg_x[g]),
            .y    (seg_y[g]),
            .cin  (seg_ci[g]),
            .s    (seg_s[g]),
            .cout (seg_co[g])
        );
    end

    // Completed difference leaving the last segment; carry out 1 means a >= b.
    assign full_s = s_q[STAGES-1];
    assign neg    = ~c_q[STAGES-1];
    assign mag    = neg ? (~full_s + DATA_W'(1)) : full_s;

    always_comb begin
        v_d         = v_q;
        c_d         = c_q;
        a_d         = a_q;
        b_d         = b_q;
        t_d         = t_q;
        s_d         = s_q;
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        absdiff_d   = absdiff_q;
        edge_d      = edge_q;
        if (advance) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_d[k]                     = src_v[k];
                c_d[k]                     = seg_co[k];
                a_d[k]                     = src_a[k];
                b_d[k]                     = src_b[k];
                t_d[k]                     = src_t[k];
                s_d[k]                     = src_s[k];
                s_d[k][k*SEG_W +: SEG_W]   = seg_s[k];
            end
            out_valid_d = v_q[STAGES-1];
            diff_d      = {neg, full_s};
            absdiff_d   = mag;
            edge_d      = mag > t_q[STAGES-1];
        end
    end

    // Valid bits and visible outputs are reset; the datapath registers are not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q         <= '0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            absdiff_q   <= '0;
            edge_q      <= 1'b0;
        end else begin
            v_q         <= v_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            absdiff_q   <= absdiff_d;
            edge_q      <= edge_d;
        end
    end

    always_ff @(posedge clk) begin
        c_q <= c_d;
        a_q <= a_d;
        b_q <= b_d;
        t_q <= t_d;
        s_q <= s_d;
    end

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.absdiff   = absdiff_q;
    assign bus.edge_flag = edge_q;

endmodule
